// File: rtl/blit_pkg.sv
// Shared widths, FSM encoding and payload structs for the rectangle blitter.
package blit_pkg;

    localparam int unsigned COLOUR_W = 6;
    localparam int unsigned XW       = 9;
    localparam int unsigned YW       = 8;
    localparam int unsigned ADDR_W   = 17;

    localparam logic [COLOUR_W-1:0] KEY_COLOUR_DEF = 6'b001100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } blit_state_e;

    typedef struct packed {
        logic [XW-1:0]       x;
        logic [YW-1:0]       y;
        logic [COLOUR_W-1:0] colour;
    } pix_entry_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [XW-1:0]     stride;
        logic [XW-1:0]     sx;
        logic [YW-1:0]     sy;
        logic [XW-1:0]     w;
        logic [YW-1:0]     h;
        logic [XW-1:0]     dx;
        logic [YW-1:0]     dy;
        logic              hflip;
        logic              key_en;
    } blit_cmd_t;

endpackage

// File: rtl/rect_scan.sv
// Raster col/row counter over a rect_w x rect_h window; wraps to 0 after the last cell.
module rect_scan
    import blit_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic [XW-1:0] rect_w,
    input  logic [YW-1:0] rect_h,
    output logic [XW-1:0] col,
    output logic [YW-1:0] row,
    output logic          last_c
);

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic          col_last, row_last;

    assign col_last = (col_q == rect_w - XW'(1));
    assign row_last = (row_q == rect_h - YW'(1));
    assign last_c   = col_last && row_last;
    assign col      = col_q;
    assign row      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + YW'(1);
            end else begin
                col_d = col_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/blit_engine.sv
// Rectangle copier: scans a source window, reads memory under a credit limit,
// and streams {x, y, colour} to the plotter through a small ready/valid FIFO.
module blit_engine
    import blit_pkg::*;
#(
    parameter int unsigned         RD_LAT     = 2,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = KEY_COLOUR_DEF,
    parameter int unsigned         FIFO_DEPTH = RD_LAT + 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [XW-1:0]       src_stride,
    input  logic [XW-1:0]       src_x,
    input  logic [YW-1:0]       src_y,
    input  logic [XW-1:0]       rect_w,
    input  logic [YW-1:0]       rect_h,
    input  logic [XW-1:0]       dst_x,
    input  logic [YW-1:0]       dst_y,
    input  logic                hflip,
    input  logic                key_en,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [COLOUR_W-1:0] rd_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW = $clog2(RD_LAT + 1);

    blit_state_e      state_q, state_d;
    blit_cmd_t        cmd_q, cmd_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [IW-1:0]    infl_q, infl_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    pix_entry_t       pe_q [RD_LAT];
    pix_entry_t       pe_d [RD_LAT];
    pix_entry_t       fifo_q [FIFO_DEPTH];
    pix_entry_t       fifo_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             scan_clr, issue, credit_ok, scan_last, ret_valid, push, pop;
    logic [XW-1:0]    col, src_col;
    logic [YW-1:0]    row;
    pix_entry_t       ret_entry, head;

    rect_scan u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (scan_clr),
        .en      (issue),
        .rect_w  (cmd_q.w),
        .rect_h  (cmd_q.h),
        .col     (col),
        .row     (row),
        .last_c  (scan_last)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Occupancy plus reads in flight bounds what can land in the FIFO.
    assign credit_ok = (32'(cnt_q) + 32'(infl_q)) < FIFO_DEPTH;
    assign issue     = (state_q == ST_ISSUE) && credit_ok;
    assign src_col   = cmd_q.hflip ? (cmd_q.w - XW'(1) - col) : col;

    assign rd_en   = issue;
    assign rd_addr = cmd_q.base
                   + (ADDR_W'(cmd_q.sy) + ADDR_W'(row)) * ADDR_W'(cmd_q.stride)
                   + ADDR_W'(cmd_q.sx) + ADDR_W'(src_col);

    assign ret_valid = pv_q[RD_LAT-1];
    assign push      = ret_valid && !(cmd_q.key_en && (rd_data == KEY_COLOUR));
    assign head      = fifo_q[rd_ptr_q];
    assign pix_valid = (cnt_q != '0);
    assign pop       = pix_valid && pix_ready;

    assign pix_x      = head.x;
    assign pix_y      = head.y;
    assign pix_colour = head.colour;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        ret_entry        = pe_q[RD_LAT-1];
        ret_entry.colour = rd_data;
    end

    // Control FSM and command latch.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        scan_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    cmd_d = '{base: src_base, stride: src_stride, sx: src_x, sy: src_y,
                              w: rect_w, h: rect_h, dx: dst_x, dy: dst_y,
                              hflip: hflip, key_en: key_en};
                    scan_clr = 1'b1;
                    state_d  = (rect_w == '0 || rect_h == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: if (issue && scan_last) state_d = ST_DRAIN;
            ST_DRAIN: if (infl_q == '0 && cnt_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Coordinate pipe matching memory latency, plus FIFO bookkeeping.
    always_comb begin
        pv_d[0]        = issue;
        pe_d[0]        = '{x: cmd_q.dx + col, y: cmd_q.dy + row, colour: '0};
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
        infl_d   = infl_q + IW'(issue) - IW'(ret_valid);
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = ret_entry;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            infl_q   <= '0;
            pv_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) pe_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            infl_q   <= infl_d;
            pv_q     <= pv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < RD_LAT; i++) pe_q[i] <= pe_d[i];
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

endmodule

// File: tb/tb_blit_engine.sv
// Directed bench for blit_engine: fixed-latency memory model, pixel capture and
// comparison against hand-derived and model-derived pixel lists.
module tb_blit_engine;
    import blit_pkg::*;

    localparam int unsigned         RD_LAT     = 2;
    localparam int unsigned         FIFO_DEPTH = RD_LAT + 2;
    localparam logic [COLOUR_W-1:0] KEY        = 6'b001100;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                go = 1'b0;
    logic [ADDR_W-1:0]   src_base = '0;
    logic [XW-1:0]       src_stride = '0, src_x = '0, rect_w = '0, dst_x = '0;
    logic [YW-1:0]       src_y = '0, rect_h = '0, dst_y = '0;
    logic                hflip = 1'b0, key_en = 1'b0;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [COLOUR_W-1:0] rd_data;
    logic                pix_valid;
    logic                pix_ready = 1'b1;
    logic [XW-1:0]       pix_x;
    logic [YW-1:0]       pix_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic                busy, done;

    always #5 clk = ~clk;

    blit_engine #(.RD_LAT(RD_LAT), .KEY_COLOUR(KEY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .go(go),
        .src_base(src_base), .src_stride(src_stride), .src_x(src_x), .src_y(src_y),
        .rect_w(rect_w), .rect_h(rect_h), .dst_x(dst_x), .dst_y(dst_y),
        .hflip(hflip), .key_en(key_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .busy(busy), .done(done)
    );

    // Fixed-latency memory model.
    logic [COLOUR_W-1:0] mem [0:1023];
    logic [COLOUR_W-1:0] rq [RD_LAT];
    always @(posedge clk) begin
        rq[0] <= rd_en ? mem[rd_addr[9:0]] : '0;
        for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
    end
    assign rd_data = rq[RD_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    pix_entry_t got_q[$];
    pix_entry_t exp_q[$];
    int         cyc = 0, first_rd = -1, first_pv = -1, done_cyc = -1;
    int         n_rd = 0, n_done = 0, ready_low = 0, credit_viol = 0;
    logic       stall_prev = 1'b0;
    pix_entry_t head_prev;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (pix_valid && first_pv < 0) first_pv = cyc;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (stall_prev && reset_n)
            check("stall_hold", 32'({pix_valid, pix_x, pix_y, pix_colour}), 32'({1'b1, head_prev}));
        if (pix_valid && pix_ready) got_q.push_back('{x: pix_x, y: pix_y, colour: pix_colour});
        ready_low = pix_ready ? 0 : ready_low + 1;
        if (ready_low > 8 && rd_en) credit_viol++;
        stall_prev = pix_valid && !pix_ready && reset_n;
        head_prev  = '{x: pix_x, y: pix_y, colour: pix_colour};
    end

    // Plotter ready pattern: 0 always ready, 1 alternating, 2 alternating then a long stall.
    int rmode = 0;
    int rcyc  = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = rcyc[0];
                default: pix_ready = (rcyc < 12) ? rcyc[0] : ((rcyc < 32) ? 1'b0 : 1'b1);
            endcase
        end
    end

    function automatic blit_cmd_t mk(input int base, input int stride, input int sx, input int sy,
                                     input int w, input int h, input int dx, input int dy,
                                     input bit hf, input bit ke);
        blit_cmd_t c;
        c = '{base: ADDR_W'(base), stride: XW'(stride), sx: XW'(sx), sy: YW'(sy),
              w: XW'(w), h: YW'(h), dx: XW'(dx), dy: YW'(dy), hflip: hf, key_en: ke};
        return c;
    endfunction

    function automatic pix_entry_t get(input int i);
        if (i < got_q.size()) return got_q[i];
        return '0;
    endfunction

    task automatic build_exp(input blit_cmd_t c);
        int a;
        logic [COLOUR_W-1:0] cv;
        exp_q.delete();
        for (int r = 0; r < int'(c.h); r++) begin
            for (int cc = 0; cc < int'(c.w); cc++) begin
                a  = int'(c.base) + (int'(c.sy) + r) * int'(c.stride) + int'(c.sx)
                   + (c.hflip ? int'(c.w) - 1 - cc : cc);
                cv = mem[a & 1023];
                if (c.key_en && cv == KEY) continue;
                exp_q.push_back('{x: XW'(int'(c.dx) + cc), y: YW'(int'(c.dy) + r), colour: cv});
            end
        end
    endtask

    task automatic start_cmd(input blit_cmd_t c, input int mode);
        @(posedge clk);
        #1;
        src_base = c.base; src_stride = c.stride; src_x = c.sx; src_y = c.sy;
        rect_w = c.w; rect_h = c.h; dst_x = c.dx; dst_y = c.dy;
        hflip = c.hflip; key_en = c.key_en;
        go = 1'b1;
        rmode = mode; rcyc = 0;
        got_q.delete();
        cyc = 0; first_rd = -1; first_pv = -1; done_cyc = -1;
        n_rd = 0; n_done = 0; credit_viol = 0;
        @(posedge clk);
        #1;
        go = 1'b0;
        // Scramble inputs: the engine must work from the latched copy.
        src_base = 17'h1F0F0; src_stride = 9'd7; src_x = 9'd5; src_y = 8'd9;
        rect_w = 9'd5; rect_h = 8'd5; dst_x = 9'd100; dst_y = 8'd100;
        hflip = ~c.hflip; key_en = ~c.key_en;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (n_done == 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_no_timeout"}, 32'(n_done != 0), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    task automatic compare(input string tag, input int reads);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_pix"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_reads"}, 32'(n_rd), 32'(reads));
        check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        blit_cmd_t c;
        int found;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        blit_cmd_t c;
        int found;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 6'((i * 5 + 3) % 64);
            if (mem[i] == KEY) mem[i] = 6'd13;
        end

        #3;
        check("reset_ctrl", 32'({rd_en, pix_valid, busy, done}), 32'd0);
        check("reset_pix", 32'({pix_x, pix_y, pix_colour}), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic copy, plus a go pulse while busy that must be ignored.
        c = mk(0, 320, 0, 0, 4, 2, 10, 20, 0, 0);
        build_exp(c);
        start_cmd(c, 0);
        repeat (3) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        check("basic_busy", 32'(busy), 32'd1);
        wait_done("basic");
        compare("basic", 8);
        check("basic_first_rd", 32'(first_rd), 32'd2);
        check("basic_first_pv", 32'(first_pv), 32'd5);
        check("basic_px0", 32'(get(0)), 32'({9'd10, 8'd20, mem[0]}));
        check("basic_px7", 32'(get(7)), 32'({9'd13, 8'd21, mem[323]}));

        // Horizontal flip.
        c = mk(0, 320, 0, 0, 4, 2, 10, 20, 1, 0);
        build_exp(c);
        start_cmd(c, 0);
        wait_done("flip");
        compare("flip", 8);
        check("flip_px0", 32'(get(0)), 32'({9'd10, 8'd20, mem[3]}));
        check("flip_px3", 32'(get(3)), 32'({9'd13, 8'd20, mem[0]}));

        // Colour key on, then off.
        mem[1] = KEY;
        c = mk(0, 320, 0, 0, 4, 2, 10, 20, 0, 1);
        build_exp(c);
        start_cmd(c, 0);
        wait_done("key");
        compare("key", 8);
        check("key_n7", 32'(got_q.size()), 32'd7);
        found = 0;
        foreach (got_q[i]) if (got_q[i].x == 9'd11 && got_q[i].y == 8'd20) found++;
        check("key_no_11_20", 32'(found), 32'd0);

        c = mk(0, 320, 0, 0, 4, 2, 10, 20, 0, 0);
        build_exp(c);
        start_cmd(c, 0);
        wait_done("nokey");
        compare("nokey", 8);
        check("nokey_n8", 32'(got_q.size()), 32'd8);
        check("nokey_px1", 32'(get(1)), 32'({9'd11, 8'd20, KEY}));
        mem[1] = 6'd8;

        // Backpressure with destination wrap in both axes.
        c = mk(100, 40, 2, 1, 6, 3, 509, 254, 0, 0);
        build_exp(c);
        start_cmd(c, 2);
        wait_done("bp");
        compare("bp", 18);
        check("bp_credit_stop", 32'(credit_viol), 32'd0);
        check("bp_px3_xwrap", 32'(get(3)), 32'({9'd0, 8'd254, mem[145]}));
        check("bp_px12_ywrap", 32'(get(12)), 32'({9'd509, 8'd0, mem[222]}));

        // Zero-size rectangles.
        c = mk(0, 320, 0, 0, 0, 3, 10, 20, 0, 0);
        build_exp(c);
        start_cmd(c, 0);
        wait_done("zero_w");
        compare("zero_w", 0);
        check("zero_w_no_pv", 32'(first_pv), 32'hFFFF_FFFF);
        check("zero_w_done_cyc", 32'(done_cyc), 32'd2);

        c = mk(0, 320, 0, 0, 4, 0, 10, 20, 0, 0);
        build_exp(c);
        start_cmd(c, 0);
        wait_done("zero_h");
        compare("zero_h", 0);
        check("zero_h_no_pv", 32'(first_pv), 32'hFFFF_FFFF);

        // Asynchronous reset mid-transfer, then a clean transfer.
        c = mk(0, 320, 0, 0, 4, 2, 10, 20, 0, 0);
        start_cmd(c, 1);
        repeat (5) @(posedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_ctrl", 32'({rd_en, pix_valid, busy, done}), 32'd0);
        check("rst_async_addr", 32'(rd_addr), 32'd0);
        check("rst_async_pix", 32'({pix_x, pix_y, pix_colour}), 32'd0);
        n_done = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        check("rst_no_done", 32'(n_done), 32'd0);

        c = mk(0, 320, 0, 0, 4, 2, 10, 20, 0, 0);
        build_exp(c);
        start_cmd(c, 1);
        wait_done("post_rst");
        compare("post_rst", 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blit_engine.md
Name: blit_engine

Overview:
- Parametrised rectangle copier: reads an arbitrary W×H window from any image or tile memory and streams it, one pixel per clock, to the pixel plotter.
- Supersedes the fixed full-screen/16×16-tile copier. Adds runtime rectangle size, source stride and base, destination offset, horizontal flip, optional colour-key transparency, and ready/valid backpressure.
- Sits between the game controller (command side) and the VGA plotter (pixel side). The memory is external and is read through a fixed-latency port.

Parameters:
- COLOUR_W, 6, bits per pixel (2 per channel).
- XW, 9, destination/source X coordinate and width field bits.
- YW, 8, Y coordinate and height field bits.
- ADDR_W, 17, memory address bits.
- RD_LAT, 2, clocks from rd_en to valid rd_data (≥1).
- KEY_COLOUR, 6'b001100, transparent colour value.
- FIFO_DEPTH, RD_LAT+2, output buffer entries.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- go  in  1  start pulse; sampled only when idle
- src_base  in  ADDR_W  word address of source image origin
- src_stride  in  XW  source row pitch in pixels
- src_x  in  XW  window left column
- src_y  in  YW  window top row
- rect_w  in  XW  window width
- rect_h  in  YW  window height
- dst_x  in  XW  screen X of window origin
- dst_y  in  YW  screen Y of window origin
- hflip  in  1  mirror horizontally
- key_en  in  1  drop KEY_COLOUR pixels
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  COLOUR_W  read data, valid RD_LAT cycles after rd_en
- pix_valid  out  1  pixel available
- pix_ready  in  1  plotter accepts pixel
- pix_x  out  XW  pixel screen X
- pix_y  out  YW  pixel screen Y
- pix_colour  out  COLOUR_W  pixel colour
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM in IDLE, FIFO empty, in-flight count 0. Takes effect immediately, including mid-transfer; the partial transfer is abandoned and no done pulse is produced.
- Command latch: go in IDLE latches all command inputs. Inputs are don't-care afterwards. go while busy is ignored.
- FSM:
  - IDLE -> ISSUE on go. If rect_w==0 or rect_h==0, go straight to DONE.
  - ISSUE -> DRAIN after the last read is issued.
  - DRAIN -> DONE when in-flight count == 0 and FIFO is empty.
  - DONE -> IDLE. done=1 for exactly the DONE cycle.
- busy=1 in every state except IDLE.
- Scan order: raster. col runs 0..rect_w-1 fastest, then row 0..rect_h-1.
- Read address: src_base + (src_y+row)*src_stride + src_x + c, modulo 2^ADDR_W. c = col normally, rect_w-1-col when hflip=1.
- Destination coordinates: pix_x = dst_x+col mod 2^XW, pix_y = dst_y+row mod 2^YW. These always use the unflipped col.
- Read issue: rd_en=1 in ISSUE only when (FIFO occupancy + in-flight reads) < FIFO_DEPTH. The scan counter advances only on issued reads. This credit rule guarantees the FIFO never overflows.
- Return path: coordinates travel alongside each read in an RD_LAT-deep shift register. On return:
  - if key_en=1 and rd_data==KEY_COLOUR, the entry is discarded and its credit freed;
  - otherwise {x, y, colour} is pushed into the FIFO.
- Output: pix_valid = FIFO not empty; pix_x, pix_y and pix_colour come from the FIFO head. An entry pops when pix_valid && pix_ready. Outputs hold stable while pix_valid=1 and pix_ready=0.
- Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Latency: go accepted at edge 0, first rd_en in the next cycle. With no keying, pix_valid rises RD_LAT+1 cycles after the first rd_en.
- Throughput: 1 pixel/clk sustained while pix_ready=1.

Decomposition:
- Package blit_pkg: COLOUR_W, XW, YW, ADDR_W, KEY_COLOUR default, FSM state encoding, and the pixel-entry struct {x, y, colour}.
- Sub-module rect_scan: col/row counter with enable, rect_w/rect_h limits and a last flag. It replaces count_xy/count8.
- FIFO and latency pipe are inline.

Test Plan:
- Basic copy: rect 4×2, src_base 0, stride 320, src (0,0), dst (10,20), pix_ready=1, RD_LAT=2 -> 8 pixels at (10..13,20..21) carrying mem[0..3] then mem[320..323]; first rd_en one cycle after go; done pulses once.
- Flip: same command with hflip=1 -> the first pixel is at (10,20) with colour mem[3], and the fourth pixel is at (13,20) with colour mem[0].
- Colour key: mem[1]=6'b001100, key_en=1 -> 7 pixels, (11,20) is never presented. With key_en=0 -> 8 pixels, including the key colour.
- Backpressure:
  - pix_ready alternating 1/0, then held low for 20 cycles -> rd_en stops once credits are exhausted;
  - no pixel is lost or duplicated, order is preserved, and head outputs stay stable while stalled.
- Zero size: rect_w=0 -> done two cycles after go; rd_en and pix_valid never assert.
- Reset and busy go: reset_n low mid-transfer -> all outputs 0 asynchronously, then a new go completes correctly. A go pulse while busy -> no effect on the current transfer.
